// File: rtl/input_conditioner_if.sv
// Raw board inputs and conditioned processor-side outputs of the input conditioner.
// The master modport is the board/environment side; slave is the conditioner.
interface input_conditioner_if;
  logic       btn_start_raw;
  logic       btn_end_raw;
  logic [7:0] switches_raw;
  logic [7:0] data_raw;
  logic       button_start;
  logic       button_end;
  logic [7:0] switches;
  logic [7:0] data_in;
  logic       bus_settling;

  modport master (
    output btn_start_raw, btn_end_raw, switches_raw, data_raw,
    input  button_start, button_end, switches, data_in, bus_settling
  );

  modport slave (
    input  btn_start_raw, btn_end_raw, switches_raw, data_raw,
    output button_start, button_end, switches, data_in, bus_settling
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces two push-buttons into single-cycle pulses and
// two 8-bit switch banks into whole-word, glitch-free buses.
module input_conditioner #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input_conditioner_if.slave   io
);
  localparam int              CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]      btn_raw;
  logic [1:0]      btn_rise;
  logic [1:0][7:0] bus_raw;
  logic [1:0][7:0] bus_out;
  logic [1:0]      bus_pending;

  logic button_start_q, button_start_d;
  logic button_end_q,   button_end_d;
  logic bus_settling_q, bus_settling_d;

  assign btn_raw    = {io.btn_end_raw, io.btn_start_raw};
  assign bus_raw[0] = io.switches_raw;
  assign bus_raw[1] = io.data_raw;

  // Index 0 is the start button, index 1 the end button.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          meta_q,   meta_d;
      logic          sync_q,   sync_d;
      logic          stable_q, stable_d;
      logic          prev_q,   prev_d;
      logic [CW-1:0] cnt_q,    cnt_d;

      always_comb begin
        meta_d   = btn_raw[gi];
        sync_d   = meta_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q   <= 1'b0;
          sync_q   <= 1'b0;
          stable_q <= 1'b0;
          prev_q   <= 1'b0;
          cnt_q    <= '0;
        end else begin
          meta_q   <= meta_d;
          sync_q   <= sync_d;
          stable_q <= stable_d;
          prev_q   <= prev_d;
          cnt_q    <= cnt_d;
        end
      end

      assign btn_rise[gi] = stable_q & ~prev_q;
    end
  endgenerate

  // Index 0 is the instruction switch bank, index 1 the data bank.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bus
      logic [7:0]    meta_q,   meta_d;
      logic [7:0]    sync_q,   sync_d;
      logic [7:0]    shadow_q, shadow_d;
      logic [7:0]    out_q,    out_d;
      logic [CW-1:0] cnt_q,    cnt_d;

      // The whole word must match its shadow for DB_CYCLES edges; any bit
      // moving restarts the count so partial patterns are never loaded.
      always_comb begin
        meta_d   = bus_raw[gi];
        sync_d   = meta_q;
        shadow_d = sync_q;
        out_d    = out_q;
        cnt_d    = '0;
        if ((sync_q == shadow_q) && (shadow_q != out_q)) begin
          if (cnt_q == CNT_LAST) begin
            out_d = shadow_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q   <= '0;
          sync_q   <= '0;
          shadow_q <= '0;
          out_q    <= '0;
          cnt_q    <= '0;
        end else begin
          meta_q   <= meta_d;
          sync_q   <= sync_d;
          shadow_q <= shadow_d;
          out_q    <= out_d;
          cnt_q    <= cnt_d;
        end
      end

      assign bus_out[gi]     = out_q;
      assign bus_pending[gi] = (shadow_q != out_q);
    end
  endgenerate

  // End takes priority: a simultaneous start is dropped.
  always_comb begin
    button_end_d   = btn_rise[1];
    button_start_d = btn_rise[0] & ~btn_rise[1];
    bus_settling_d = |bus_pending;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      button_start_q <= 1'b0;
      button_end_q   <= 1'b0;
      bus_settling_q <= 1'b0;
    end else begin
      button_start_q <= button_start_d;
      button_end_q   <= button_end_d;
      bus_settling_q <= bus_settling_d;
    end
  end

  assign io.button_start = button_start_q;
  assign io.button_end   = button_end_q;
  assign io.switches     = bus_out[0];
  assign io.data_in      = bus_out[1];
  assign io.bus_settling = bus_settling_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DB_CYCLES=4 (pulse/bus latency 6 edges).
module tb_input_conditioner;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  input_conditioner_if bus ();

  input_conditioner #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    bus.btn_start_raw = 1'b0;
    bus.btn_end_raw   = 1'b0;
    bus.switches_raw  = 8'h00;
    bus.data_raw      = 8'h00;
    #2;
    chk1("rst_start",    bus.button_start, 1'b0);
    chk1("rst_end",      bus.button_end,   1'b0);
    chk8("rst_switches", bus.switches,     8'h00);
    chk8("rst_data",     bus.data_in,      8'h00);
    chk1("rst_settling", bus.bus_settling, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    edges(3);
    chk1("idle_start", bus.button_start, 1'b0);

    // Start button held: one pulse right after edge 6, nothing while held or on release.
    bus.btn_start_raw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      edges(1);
      chk1($sformatf("start_e%0d", i), bus.button_start, i == 6);
      chk1($sformatf("start_noend_e%0d", i), bus.button_end, 1'b0);
    end
    bus.btn_start_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      chk1($sformatf("start_rel_e%0d", i), bus.button_start, 1'b0);
    end

    // End button bounce 3 high / 1 low, then held 10: pulse 6 edges after edge 4.
    for (int i = 0; i < 24; i++) begin
      bus.btn_end_raw = (i < 3) || (i >= 4 && i < 14);
      edges(1);
      chk1($sformatf("end_bounce_e%0d", i), bus.button_end, i == 10);
    end
    bus.btn_end_raw = 1'b0;
    edges(10);

    // Simultaneous press: end wins, start is dropped.
    bus.btn_start_raw = 1'b1;
    bus.btn_end_raw   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      chk1($sformatf("both_end_e%0d", i), bus.button_end, i == 6);
      chk1($sformatf("both_start_e%0d", i), bus.button_start, 1'b0);
    end
    bus.btn_start_raw = 1'b0;
    bus.btn_end_raw   = 1'b0;
    edges(10);

    // Switch word held: loads after edge 6, settling flagged on edges 3..6.
    bus.switches_raw = 8'hA5;
    for (int i = 0; i < 9; i++) begin
      edges(1);
      chk8($sformatf("sw_e%0d", i), bus.switches, (i >= 6) ? 8'hA5 : 8'h00);
      chk1($sformatf("settle_e%0d", i), bus.bus_settling, (i >= 3) && (i <= 6));
    end

    // Reset with the start counter at 2 and switches loaded; both must rebuild from scratch.
    bus.btn_start_raw = 1'b1;
    edges(4);
    reset = 1'b1;
    #2;
    chk1("midrst_start",    bus.button_start, 1'b0);
    chk8("midrst_switches", bus.switches,     8'h00);
    chk1("midrst_settling", bus.bus_settling, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      edges(1);
      chk1($sformatf("postrst_start_e%0d", i), bus.button_start, i == 6);
      chk8($sformatf("postrst_sw_e%0d", i), bus.switches, (i >= 6) ? 8'hA5 : 8'h00);
    end
    bus.btn_start_raw = 1'b0;
    bus.switches_raw  = 8'h00;
    edges(10);
    chk8("sw_back_zero", bus.switches, 8'h00);

    // Switches changing every 2 cycles never satisfy the hold time.
    for (int i = 0; i < 20; i++) begin
      bus.switches_raw = ((i / 2) % 2 == 0) ? 8'hA5 : 8'h00;
      edges(1);
      chk8($sformatf("sw_toggle_e%0d", i), bus.switches, 8'h00);
    end
    bus.switches_raw = 8'h00;
    edges(8);

    // Data 3C for 10 cycles then C3: each accepted 6 edges after it appears.
    for (int i = 0; i < 22; i++) begin
      bus.data_raw = (i < 10) ? 8'h3C : 8'hC3;
      edges(1);
      chk8($sformatf("data_e%0d", i), bus.data_in,
           (i < 6) ? 8'h00 : ((i < 16) ? 8'h3C : 8'hC3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive clk cycles an input must hold a new value before it is accepted (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_start_raw  input  1  unsynchronised start push-button.
REQ-005 SHALL have port btn_end_raw  input  1  unsynchronised end push-button.
REQ-006 SHALL have port switches_raw  input  8  unsynchronised instruction switches.
REQ-007 SHALL have port data_raw  input  8  unsynchronised data switches.
REQ-008 SHALL have port button_start  output  1  one-cycle start pulse to the processor.
REQ-009 SHALL have port button_end  output  1  one-cycle end pulse to the processor.
REQ-010 SHALL have port switches  output  8  debounced instruction bus.
REQ-011 SHALL have port data_in  output  8  debounced data bus.
REQ-012 SHALL have port bus_settling  output  1  high while either bus has a pending, not-yet-accepted change.

Function
REQ-013 SHALL pass every raw input through a 2-flop synchroniser; "sync value" means the second-flop output.
REQ-014 SHALL keep per button a stable bit and a counter; each edge: sync == stable -> counter cleared; sync != stable -> counter increments.
REQ-015 SHALL, on an edge where sync != stable and counter == DB_CYCLES-1, toggle stable and clear counter.
REQ-016 SHALL assert a button pulse for exactly one cycle, registered on the edge where that button's stable bit goes 0->1; no pulse on 1->0.
REQ-017 SHALL give latency DB_CYCLES+2 edges from the first edge sampling raw high (held steady) to the edge asserting the pulse.
REQ-018 SHALL discard any bounce shorter than DB_CYCLES cycles (counter clears on return to stable value).
REQ-019 SHALL issue at most one pulse per press, regardless of hold time.
REQ-020 SHALL, if both start and end pulses would assert on the same edge, assert button_end only and drop the start pulse.
REQ-021 SHALL treat each 8-bit bus as one unit: a shadow register holds the last sync sample; a counter clears whenever sync != shadow and increments when sync == shadow != output.
REQ-022 SHALL load the bus output from shadow when the counter reaches DB_CYCLES-1, then clear the counter.
REQ-023 SHALL hold bus outputs constant between accepted updates; partial or changing patterns never appear on outputs.
REQ-024 SHALL drive bus_settling = (switches shadow != switches) OR (data shadow != data_in), registered.
REQ-025 SHALL use saturating-free counters of width clog2(DB_CYCLES); the counter never exceeds DB_CYCLES-1.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all synchroniser flops, stable bits, shadows, counters and outputs (button_start=0, button_end=0, switches=8'h00, data_in=8'h00, bus_settling=0).
REQ-027 SHALL, on reset mid-debounce, discard the pending change; a button still held after release of reset requires full DB_CYCLES+2 latency and then produces one pulse.
REQ-028 SHALL, after reset release, accept a non-zero bus value held from reset after DB_CYCLES+2 edges (shadow fill + count).

Verification (DB_CYCLES=4)
REQ-029 SHALL cover: btn_start_raw held high from edge 0 -> button_start high only in the cycle after edge 6, low thereafter while held.
REQ-030 SHALL cover: btn_end_raw high 3 cycles, low 1, high 10 -> single button_end pulse 6 edges after the final rising sample; no earlier pulse.
REQ-031 SHALL cover: both raw buttons rise on the same edge and hold -> button_end pulses once, button_start never pulses.
REQ-032 SHALL cover: switches_raw 8'hA5 held -> switches becomes 8'hA5 after 6 edges, bus_settling high from edge 3 until update; toggling bits every 2 cycles -> switches stays 8'h00.
REQ-033 SHALL cover: reset asserted at counter==2 while btn_start_raw high -> outputs 0 immediately; after release, one pulse exactly 6 edges later.
REQ-034 SHALL cover: data_raw 8'h3C then 8'hC3 after 10 cycles -> data_in 8'h3C then 8'hC3, each change after 6 edges, never an intermediate value.
